// File: rtl/ov5640_pwr_seq.sv
// Power-up / bring-up sequencer for the OV5640 camera path: sensor PWDN/RESETB
// timing, config-engine release with timeout, and frame skipping before cam_ready.
module ov5640_pwr_seq #(
  parameter logic [27:0] T_PWDN_CYC  = 28'd300_000,
  parameter logic [27:0] T_RST_CYC   = 28'd100_000,
  parameter logic [27:0] T_BOOT_CYC  = 28'd1_100_000,
  parameter logic [27:0] CFG_TMO_CYC = 28'd100_000_000,
  parameter logic [7:0]  SKIP_FRAMES = 8'd10
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       soft_restart,
  input  logic       cfg_done,
  input  logic       ov5640_vsync,
  output logic       ov5640_pwdn,
  output logic       ov5640_rst_n,
  output logic       cfg_rst_n,
  output logic       cam_ready,
  output logic       timeout_err,
  output logic [2:0] seq_state
);

  localparam int unsigned CNT_W = 28;
  localparam int unsigned FR_W  = 8;

  // Terminal counts; a zero duration still occupies one cycle.
  localparam logic [CNT_W-1:0] PWDN_LAST = (T_PWDN_CYC  == '0) ? '0 : T_PWDN_CYC  - CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST  = (T_RST_CYC   == '0) ? '0 : T_RST_CYC   - CNT_W'(1);
  localparam logic [CNT_W-1:0] BOOT_LAST = (T_BOOT_CYC  == '0) ? '0 : T_BOOT_CYC  - CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LAST  = (CFG_TMO_CYC == '0) ? '0 : CFG_TMO_CYC - CNT_W'(1);

  typedef enum logic [2:0] {
    S_PWDN  = 3'd0,
    S_RST   = 3'd1,
    S_BOOT  = 3'd2,
    S_CFG   = 3'd3,
    S_SKIP  = 3'd4,
    S_READY = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_c;
  logic [FR_W-1:0]   fr_q, fr_d, fr_inc_c;
  logic              cfg_meta_q, cfg_sync_q;
  logic              vs_meta_q, vs_sync_q, vs_prev_q;
  logic              vs_edge_c;
  logic              pwdn_q, pwdn_d;
  logic              sens_rst_n_q, sens_rst_n_d;
  logic              cfg_rst_n_q, cfg_rst_n_d;
  logic              ready_q, ready_d;
  logic              tmo_q, tmo_d;

  // Two-flop synchronisers for the foreign-domain levels plus vsync edge history.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cfg_meta_q <= 1'b0;
      cfg_sync_q <= 1'b0;
      vs_meta_q  <= 1'b0;
      vs_sync_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
    end else begin
      cfg_meta_q <= cfg_done;
      cfg_sync_q <= cfg_meta_q;
      vs_meta_q  <= ov5640_vsync;
      vs_sync_q  <= vs_meta_q;
      vs_prev_q  <= vs_sync_q;
    end
  end

  assign vs_edge_c = vs_sync_q & ~vs_prev_q;

  // State, counters and registered pin outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_PWDN;
      cnt_q        <= '0;
      fr_q         <= '0;
      pwdn_q       <= 1'b1;
      sens_rst_n_q <= 1'b0;
      cfg_rst_n_q  <= 1'b0;
      ready_q      <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fr_q         <= fr_d;
      pwdn_q       <= pwdn_d;
      sens_rst_n_q <= sens_rst_n_d;
      cfg_rst_n_q  <= cfg_rst_n_d;
      ready_q      <= ready_d;
      tmo_q        <= tmo_d;
    end
  end

  // Next-state, counter and output decode; outputs follow the next state so pins track seq_state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fr_d         = fr_q;
    pwdn_d       = 1'b1;
    sens_rst_n_d = 1'b0;
    cfg_rst_n_d  = 1'b0;
    ready_d      = 1'b0;
    tmo_d        = tmo_q;
    // Saturating so that cnt_q==0 marks only the first cycle of a state.
    cnt_inc_c    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    fr_inc_c     = fr_q + FR_W'(1);

    case (state_q)
      S_PWDN: if (cnt_q == PWDN_LAST) state_d = S_RST;
      S_RST:  if (cnt_q == RST_LAST)  state_d = S_BOOT;
      S_BOOT: if (cnt_q == BOOT_LAST) state_d = S_CFG;
      S_CFG: begin
        if (cfg_sync_q)                state_d = S_SKIP;
        else if (cnt_q == TMO_LAST)    state_d = S_ERR;
      end
      S_SKIP: begin
        if (SKIP_FRAMES == '0) begin
          state_d = S_READY;
        end else if (vs_edge_c && (cnt_q != '0)) begin
          fr_d = fr_inc_c;
          if (fr_inc_c == SKIP_FRAMES) state_d = S_READY;
        end
      end
      S_READY: state_d = S_READY;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_PWDN;
    endcase

    if (soft_restart) begin
      state_d = S_PWDN;
    end

    // Counter restarts on every state entry; terminal states leave it frozen.
    if (soft_restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q != S_READY) && (state_q != S_ERR)) begin
      cnt_d = cnt_inc_c;
    end

    if (soft_restart || ((state_d == S_SKIP) && (state_q != S_SKIP))) begin
      fr_d = '0;
    end

    if (soft_restart) begin
      tmo_d = 1'b0;
    end else if (state_d == S_ERR) begin
      tmo_d = 1'b1;
    end

    case (state_d)
      S_RST: begin
        pwdn_d = 1'b0;
      end
      S_BOOT: begin
        pwdn_d       = 1'b0;
        sens_rst_n_d = 1'b1;
      end
      S_CFG, S_SKIP: begin
        pwdn_d       = 1'b0;
        sens_rst_n_d = 1'b1;
        cfg_rst_n_d  = 1'b1;
      end
      S_READY: begin
        pwdn_d       = 1'b0;
        sens_rst_n_d = 1'b1;
        cfg_rst_n_d  = 1'b1;
        ready_d      = 1'b1;
      end
      default: begin
        pwdn_d = 1'b1;
      end
    endcase
  end

  assign ov5640_pwdn  = pwdn_q;
  assign ov5640_rst_n = sens_rst_n_q;
  assign cfg_rst_n    = cfg_rst_n_q;
  assign cam_ready    = ready_q;
  assign timeout_err  = tmo_q;
  assign seq_state    = state_q;

endmodule

// File: tb/tb_ov5640_pwr_seq.sv
// Scoreboard bench for ov5640_pwr_seq: directed stimulus pushes expected output
// changes (cycle + pin pattern); a negedge monitor pops one per observed change.
`timescale 1ns/1ps
module tb_ov5640_pwr_seq;

  typedef struct {
    int         dut;
    int         cyc;
    logic [7:0] val;
    string      nm;
  } exp_t;

  localparam logic [7:0] RST_V = 8'b000_1000_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n = 1'b0, soft0 = 1'b0, cfg0 = 1'b0, vs0 = 1'b0;
  logic rst1_n = 1'b0, soft1 = 1'b0, cfg1 = 1'b0, vs1 = 1'b0;
  logic pwdn0, srst0, crst0, rdy0, tmo0;
  logic pwdn1, srst1, crst1, rdy1, tmo1;
  logic [2:0] st0, st1;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  exp_t expq[$];
  logic [7:0] obs [2];
  logic [7:0] prev [2];

  ov5640_pwr_seq #(
    .T_PWDN_CYC(28'd4), .T_RST_CYC(28'd3), .T_BOOT_CYC(28'd5),
    .CFG_TMO_CYC(28'd50), .SKIP_FRAMES(8'd2)
  ) u0 (
    .sys_clk(clk), .sys_rst_n(rst0_n), .soft_restart(soft0), .cfg_done(cfg0),
    .ov5640_vsync(vs0), .ov5640_pwdn(pwdn0), .ov5640_rst_n(srst0), .cfg_rst_n(crst0),
    .cam_ready(rdy0), .timeout_err(tmo0), .seq_state(st0)
  );

  ov5640_pwr_seq #(
    .T_PWDN_CYC(28'd4), .T_RST_CYC(28'd3), .T_BOOT_CYC(28'd5),
    .CFG_TMO_CYC(28'd50), .SKIP_FRAMES(8'd0)
  ) u1 (
    .sys_clk(clk), .sys_rst_n(rst1_n), .soft_restart(soft1), .cfg_done(cfg1),
    .ov5640_vsync(vs1), .ov5640_pwdn(pwdn1), .ov5640_rst_n(srst1), .cfg_rst_n(crst1),
    .cam_ready(rdy1), .timeout_err(tmo1), .seq_state(st1)
  );

  assign obs[0] = {st0, pwdn0, srst0, crst0, rdy0, tmo0};
  assign obs[1] = {st1, pwdn1, srst1, crst1, rdy1, tmo1};

  always @(posedge clk) cyc <= cyc + 1;

  // Expected {state, pwdn, rst_n, cfg_rst_n, cam_ready, timeout_err} for a state.
  function automatic logic [7:0] mk(input logic [2:0] st, input logic tmo);
    logic [3:0] p;
    case (st)
      3'd0: p = 4'b1000;
      3'd1: p = 4'b0000;
      3'd2: p = 4'b0100;
      3'd3: p = 4'b0110;
      3'd4: p = 4'b0110;
      3'd5: p = 4'b0111;
      default: p = 4'b1000;
    endcase
    return {st, p, tmo};
  endfunction

  task automatic expect_at(input int d, input int c, input logic [2:0] st,
                           input logic tmo, input string nm);
    exp_t e;
    e.dut = d; e.cyc = c; e.val = mk(st, tmo); e.nm = nm;
    expq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", nm, got, req);
    end
  endtask

  task automatic go(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every output change on either DUT must match the head of the queue.
  initial begin
    prev[0] = RST_V;
    prev[1] = RST_V;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (obs[d] !== prev[d]) begin
          n_cmp++;
          if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change dut%0d cyc=%0d got %b required no change",
                     d, cyc, obs[d]);
          end else begin
            exp_t e;
            e = expq.pop_front();
            if (e.dut != d || e.cyc != cyc || e.val !== obs[d]) begin
              n_fail++;
              $display("FAIL %s: got dut%0d cyc=%0d val=%b required dut%0d cyc=%0d val=%b",
                       e.nm, d, cyc, obs[d], e.dut, e.cyc, e.val);
            end
          end
          prev[d] = obs[d];
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int r, p, q, w, r3, c3;

    // Reset state on both instances.
    go(3);
    chk("reset_u0", obs[0], RST_V);
    chk("reset_u1", obs[1], RST_V);

    // Nominal bring-up.
    r = cyc;
    expect_at(0, r + 4,  3'd1, 1'b0, "nom_rst");
    expect_at(0, r + 7,  3'd2, 1'b0, "nom_boot");
    expect_at(0, r + 12, 3'd3, 1'b0, "nom_cfg");
    expect_at(0, r + 25, 3'd4, 1'b0, "nom_skip");
    expect_at(0, r + 37, 3'd5, 1'b0, "nom_ready");
    rst0_n = 1'b1;
    go(r + 22); cfg0 = 1'b1;
    go(r + 28); vs0 = 1'b1;
    go(r + 30); vs0 = 1'b0;
    go(r + 34); vs0 = 1'b1;
    go(r + 36); vs0 = 1'b0;
    // Input activity in READY must not move anything.
    go(r + 40); vs0 = 1'b1;
    go(r + 42); vs0 = 1'b0;
    go(r + 44); vs0 = 1'b1; cfg0 = 1'b0;
    go(r + 46); vs0 = 1'b0;
    go(r + 50);
    chk("ready_hold", obs[0], mk(3'd5, 1'b0));

    // Restart from READY, then soft_restart on cycle 2 of BOOT.
    p = cyc;
    expect_at(0, p + 1,  3'd0, 1'b0, "rs_pwdn");
    expect_at(0, p + 5,  3'd1, 1'b0, "rs_rst");
    expect_at(0, p + 8,  3'd2, 1'b0, "rs_boot");
    expect_at(0, p + 10, 3'd0, 1'b0, "midboot_pwdn");
    expect_at(0, p + 14, 3'd1, 1'b0, "midboot_rst");
    expect_at(0, p + 17, 3'd2, 1'b0, "midboot_boot");
    expect_at(0, p + 22, 3'd3, 1'b0, "midboot_cfg");
    expect_at(0, p + 72, 3'd6, 1'b1, "tmo_err");
    soft0 = 1'b1;
    go(p + 1); soft0 = 1'b0;
    go(p + 9); soft0 = 1'b1;
    go(p + 10); soft0 = 1'b0;

    // Timeout recovery, then a vsync edge coincident with SKIP entry.
    q = p + 80;
    go(q);
    expect_at(0, q + 1,  3'd0, 1'b0, "tr_pwdn");
    expect_at(0, q + 5,  3'd1, 1'b0, "tr_rst");
    expect_at(0, q + 8,  3'd2, 1'b0, "tr_boot");
    expect_at(0, q + 13, 3'd3, 1'b0, "tr_cfg");
    expect_at(0, q + 23, 3'd4, 1'b0, "coinc_skip");
    expect_at(0, q + 37, 3'd5, 1'b0, "coinc_ready");
    soft0 = 1'b1;
    go(q + 1);  soft0 = 1'b0;
    go(q + 20); cfg0 = 1'b1;
    go(q + 21); vs0 = 1'b1;
    go(q + 25); vs0 = 1'b0;
    go(q + 28); vs0 = 1'b1;
    go(q + 30); vs0 = 1'b0;
    go(q + 34); vs0 = 1'b1;
    go(q + 36); vs0 = 1'b0;
    go(q + 40); cfg0 = 1'b0;

    // Async reset while in SKIP.
    w = q + 45;
    go(w);
    expect_at(0, w + 1,  3'd0, 1'b0, "ar_pwdn");
    expect_at(0, w + 5,  3'd1, 1'b0, "ar_rst");
    expect_at(0, w + 8,  3'd2, 1'b0, "ar_boot");
    expect_at(0, w + 13, 3'd3, 1'b0, "ar_cfg");
    expect_at(0, w + 23, 3'd4, 1'b0, "ar_skip");
    expect_at(0, w + 27, 3'd0, 1'b0, "ar_reset_seen");
    soft0 = 1'b1;
    go(w + 1);  soft0 = 1'b0;
    go(w + 20); cfg0 = 1'b1;
    go(w + 26);
    #2;
    rst0_n = 1'b0;
    cfg0 = 1'b0;
    #1;
    chk("async_reset_immediate", obs[0], RST_V);

    // SKIP_FRAMES=0 instance with cfg_done coinciding with the timeout count.
    go(w + 30);
    r3 = cyc;
    c3 = r3 + 12;
    expect_at(1, r3 + 4, 3'd1, 1'b0, "z_rst");
    expect_at(1, r3 + 7, 3'd2, 1'b0, "z_boot");
    expect_at(1, c3,     3'd3, 1'b0, "z_cfg");
    expect_at(1, c3 + 50, 3'd4, 1'b0, "z_coinc_skip");
    expect_at(1, c3 + 51, 3'd5, 1'b0, "z_ready");
    rst1_n = 1'b1;
    go(c3 + 47); cfg1 = 1'b1;
    go(c3 + 56);

    n_cmp++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations: got %0d left (next %s) required 0",
               expq.size(), expq[0].nm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
